// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Stateful operand-forwarding and load-use stall unit placed between ID and
// the ID/EX register. A shifting scoreboard remembers the destination of
// every instruction issued in the last STAGES cycles. From it, each operand
// of the instruction in ID gets a forwarding select that is registered into
// EX. A load-use stall is raised while a load result cannot be forwarded yet.
module hazard_forward_unit #(
  parameter int REG_AW     = 3,
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 2,
  parameter bit ZERO_REG   = 1'b1,
  localparam int FW        = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic [REG_AW-1:0] id_src_c,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_use_c,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              flush,
  output logic              stall,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic [FW-1:0]     fwd_c,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic              ld;
  } ent_t;

  // Index 0 is the instruction now in EX, STAGES-1 the one in WB.
  ent_t        ent_q [STAGES];
  ent_t        ent_d;

  logic [FW-1:0] fwd_a_q, fwd_b_q, fwd_c_q;
  logic [FW-1:0] sel_a_d, sel_b_d, sel_c_d;
  logic          haz_a, haz_b, haz_c;
  logic          issue;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  // Youngest matching producer in ent[0..STAGES-2]. The loop walks from oldest
  // to youngest so a younger match overwrites an older one. A producer only in
  // the last entry is handled by the write-first register file (select 0).
  function automatic void lookup(input  logic              use_s,
                                 input  logic [REG_AW-1:0] src,
                                 output logic [FW-1:0]     sel,
                                 output logic              haz);
    sel = '0;
    haz = 1'b0;
    if (use_s && !(ZERO_REG && src == '0)) begin
      for (int k = STAGES - 2; k >= 0; k--) begin
        if (ent_q[k].v && ent_q[k].dst == src) begin
          sel = FW'(k + 1);
          haz = ent_q[k].ld && ((k + 1) < LOAD_READY);
        end
      end
    end
  endfunction

  // Operand lookup, stall decision and next scoreboard head entry.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    ent_d       = '0;
    stall_cnt_d = stall_cnt_q;
    lookup(id_use_a, id_src_a, sel_a_d, haz_a);
    lookup(id_use_b, id_src_b, sel_b_d, haz_b);
    lookup(id_use_c, id_src_c, sel_c_d, haz_c);
    stall = id_valid && !flush && (haz_a || haz_b || haz_c);
    issue = id_valid && !flush && !stall;
    if (issue) begin
      ent_d.v   = id_wr && ((id_dst != '0) || !ZERO_REG);
      ent_d.dst = id_dst;
      ent_d.ld  = id_load;
    end
    if (stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Scoreboard shift, registered selects and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, and its valid
      // bits must clear on reset so stale producers are forgotten; resetting
      // every entry is therefore both required and cheap.
      for (int k = 0; k < STAGES; k++) begin
        ent_q[k] <= '0;
      end
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      fwd_c_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every entry shift from its
      // pre-edge value; blocking ones would collapse the whole shift chain.
      for (int k = 1; k < STAGES; k++) begin
        ent_q[k] <= ent_q[k-1];
      end
      ent_q[0]    <= ent_d;
      fwd_a_q     <= issue ? sel_a_d : '0;
      fwd_b_q     <= issue ? sel_b_d : '0;
      fwd_c_q     <= issue ? sel_c_d : '0;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign fwd_c     = fwd_c_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit: directed pipeline scenarios plus random
// traffic against a history-based reference model, and a saturation run on
// a deep-pipeline instance.
module tb_hazard_forward_unit;

  localparam int M_STAGES = 3;
  localparam int M_LR     = 2;

  logic       clk = 1'b0;
  logic       rst, rst_sat;
  logic       id_valid, id_use_a, id_use_b, id_use_c, id_wr, id_load, flush;
  logic [2:0] id_src_a, id_src_b, id_src_c, id_dst;
  logic       stall;
  logic [1:0] fwd_a, fwd_b, fwd_c;
  logic [15:0] stall_cnt;

  logic       s_stall;
  logic [3:0] s_fwd_a, s_fwd_b, s_fwd_c;
  logic [15:0] s_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_src_c(id_src_c),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_c(id_use_c),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall_cnt(stall_cnt)
  );

  // Deep pipeline: a load followed by "lw r1 <- r1" costs 14 stalls per
  // 15 cycles, which lets the counter saturate in about 70k cycles.
  hazard_forward_unit #(.REG_AW(3), .STAGES(16), .LOAD_READY(15), .ZERO_REG(1'b1)) dut_sat (
    .clk(clk), .rst(rst_sat), .id_valid(1'b1),
    .id_src_a(3'd1), .id_src_b(3'd0), .id_src_c(3'd0),
    .id_use_a(1'b1), .id_use_b(1'b0), .id_use_c(1'b0),
    .id_dst(3'd1), .id_wr(1'b1), .id_load(1'b1), .flush(1'b0),
    .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_c(s_fwd_c),
    .stall_cnt(s_stall_cnt)
  );

  // Reference model: hist[n] is what was issued n+1 cycles ago (bubble = no write).
  typedef struct {
    bit       wr;
    bit [2:0] dst;
    bit       ld;
  } rec_t;

  rec_t    hist[$];
  int      exp_fa, exp_fb, exp_fc;
  int      exp_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A producer issued `age` cycles before the consumer will be `age` stages
  // ahead of it once the consumer is in EX; it is on the bus of stage `age`.
  function automatic void m_lookup(input bit use_s, input bit [2:0] s,
                                   output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (!use_s || s == 3'd0) return;
    for (int age = 1; age <= M_STAGES - 1 && age <= hist.size(); age++) begin
      if (hist[age-1].wr && hist[age-1].dst == s) begin
        sel = age;
        haz = hist[age-1].ld && (age < M_LR);
        return;
      end
    end
  endfunction

  task automatic m_reset();
    hist.delete();
    exp_fa = 0; exp_fb = 0; exp_fc = 0;
    exp_cnt = 0;
  endtask

  // One ID cycle: drive, check stall mid-cycle, clock, check registered outputs.
  task automatic step(input bit v, input bit [2:0] a, input bit [2:0] b, input bit [2:0] c,
                      input bit ua, input bit ub, input bit uc,
                      input bit [2:0] d, input bit wr, input bit ld, input bit fl);
    int  sa, sb, sc;
    bit  ha, hb, hc, est, iss;
    rec_t r;
    id_valid = v; id_src_a = a; id_src_b = b; id_src_c = c;
    id_use_a = ua; id_use_b = ub; id_use_c = uc;
    id_dst = d; id_wr = wr; id_load = ld; flush = fl;
    @(negedge clk);
    m_lookup(ua, a, sa, ha);
    m_lookup(ub, b, sb, hb);
    m_lookup(uc, c, sc, hc);
    est = v && !fl && (ha || hb || hc);
    iss = v && !fl && !est;
    chk("stall", {15'd0, stall}, {15'd0, est});
    @(posedge clk);
    r.wr  = iss && wr && (d != 3'd0);
    r.dst = d;
    r.ld  = ld;
    hist.push_front(r);
    if (hist.size() > M_STAGES) void'(hist.pop_back());
    exp_fa = iss ? sa : 0;
    exp_fb = iss ? sb : 0;
    exp_fc = iss ? sc : 0;
    if (est && exp_cnt < 65535) exp_cnt++;
    #1;
    chk("fwd_a", {14'd0, fwd_a}, exp_fa[15:0]);
    chk("fwd_b", {14'd0, fwd_b}, exp_fb[15:0]);
    chk("fwd_c", {14'd0, fwd_c}, exp_fc[15:0]);
    chk("stall_cnt", stall_cnt, exp_cnt[15:0]);
  endtask

  initial begin
    rst = 1'b1; rst_sat = 1'b1;
    id_valid = 0; id_src_a = 0; id_src_b = 0; id_src_c = 0;
    id_use_a = 0; id_use_b = 0; id_use_c = 0;
    id_dst = 0; id_wr = 0; id_load = 0; flush = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fwd_a", {14'd0, fwd_a}, 16'd0);
    chk("reset_cnt", stall_cnt, 16'd0);
    chk("reset_stall", {15'd0, stall}, 16'd0);
    rst = 1'b0;

    // ALU chain back-to-back: add r1 <- r2 ; add r2 <- r1,r1
    step(1, 3'd2, 3'd0, 3'd0, 1, 0, 0, 3'd1, 1, 0, 0);
    step(1, 3'd1, 3'd1, 3'd0, 1, 1, 0, 3'd2, 1, 0, 0);
    chk("chain_fa", {14'd0, fwd_a}, 16'd1);
    chk("chain_fb", {14'd0, fwd_b}, 16'd1);
    // One independent instruction between producer and consumer
    step(1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 3'd1, 1, 0, 0);
    step(1, 3'd7, 3'd0, 3'd0, 1, 0, 0, 3'd6, 1, 0, 0);
    step(1, 3'd1, 3'd0, 3'd0, 1, 0, 0, 3'd4, 1, 0, 0);
    chk("gap_fa", {14'd0, fwd_a}, 16'd2);

    // Load-use: lw r3 ; add r4 <- r3 (one stall, bubble, then fwd 2)
    step(1, 3'd5, 3'd0, 3'd0, 1, 0, 0, 3'd3, 1, 1, 0);
    step(1, 3'd3, 3'd0, 3'd0, 1, 0, 0, 3'd4, 1, 0, 0);
    chk("lu_bubble_fa", {14'd0, fwd_a}, 16'd0);
    chk("lu_cnt", stall_cnt, 16'd1);
    step(1, 3'd3, 3'd0, 3'd0, 1, 0, 0, 3'd4, 1, 0, 0);
    chk("lu_fa", {14'd0, fwd_a}, 16'd2);

    // Zero register and unused operand
    step(1, 3'd1, 3'd0, 3'd0, 1, 0, 0, 3'd0, 1, 0, 0);
    step(1, 3'd0, 3'd0, 3'd0, 1, 0, 0, 3'd5, 1, 0, 0);
    chk("zero_fa", {14'd0, fwd_a}, 16'd0);
    step(1, 3'd2, 3'd0, 3'd0, 1, 0, 0, 3'd6, 1, 0, 0);
    step(1, 3'd7, 3'd6, 3'd0, 1, 0, 0, 3'd2, 1, 0, 0);
    chk("imm_fb", {14'd0, fwd_b}, 16'd0);

    // Youngest wins, store data
    step(1, 3'd1, 3'd0, 3'd0, 1, 0, 0, 3'd5, 1, 0, 0);
    step(1, 3'd2, 3'd0, 3'd0, 1, 0, 0, 3'd5, 1, 0, 0);
    step(1, 3'd4, 3'd0, 3'd5, 1, 0, 1, 3'd0, 0, 0, 0);
    chk("store_fc", {14'd0, fwd_c}, 16'd1);

    // Flush beats a load-use hazard
    step(1, 3'd1, 3'd0, 3'd0, 1, 0, 0, 3'd2, 1, 1, 0);
    step(1, 3'd2, 3'd0, 3'd2, 1, 0, 1, 3'd0, 0, 0, 1);
    chk("flush_fa", {14'd0, fwd_a}, 16'd0);
    chk("flush_fc", {14'd0, fwd_c}, 16'd0);

    // Same source on all three operands
    step(1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 3'd7, 1, 0, 0);
    step(1, 3'd7, 3'd7, 3'd7, 1, 1, 1, 3'd0, 0, 0, 0);
    chk("same_fb", {14'd0, fwd_b}, 16'd1);

    // Reset mid-stall: lw r3 then consumer of r3, reset while stall is high
    step(1, 3'd1, 3'd0, 3'd0, 1, 0, 0, 3'd3, 1, 1, 0);
    id_valid = 1; id_src_a = 3'd3; id_use_a = 1; id_use_b = 0; id_use_c = 0;
    id_dst = 3'd4; id_wr = 1; id_load = 0; flush = 0;
    @(negedge clk);
    chk("pre_rst_stall", {15'd0, stall}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_fa", {14'd0, fwd_a}, 16'd0);
    chk("rst_cnt", stall_cnt, 16'd0);
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 3'd3, 3'd0, 3'd0, 1, 0, 0, 3'd4, 1, 0, 0);
    chk("post_rst_fa", {14'd0, fwd_a}, 16'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) != 0,
           3'($urandom), 3'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0,
           ($urandom % 10) == 0);
    end
    id_valid = 0; flush = 0;

    // Saturation on the deep instance
    @(posedge clk);
    #1 rst_sat = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("sat_first_period", s_stall_cnt, 16'd14);
    repeat (71000) @(posedge clk);
    #1;
    chk("sat_hold", s_stall_cnt, 16'hFFFF);
    repeat (20) @(posedge clk);
    #1;
    chk("sat_stay", s_stall_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
